// File: rtl/adb_poller.sv
// adb_poller -- host-side ADB transaction sequencer.
//
// Drives the ADB device model's state lines, command/data bytes and byte
// strobes, and collects Talk response bytes. CPU requests and a built-in
// autopoll scheduler share the bus. When both want it on the same tick, the
// CPU wins. Autopoll issues Talk R0 to the keyboard or the mouse.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   clk_en            tick enable; state only moves when high
//   req/req_ready     CPU request handshake; req_cmd {addr,cmd}, req_data
//   done/timeout      end-of-CPU-transaction pulse and short-Talk flag
//   rsp_data/rsp_cnt  captured Talk bytes (high byte first) and byte count
//   autopoll_en       enables the autopoll scheduler
//   poll_valid/addr   autopoll completed with two bytes from poll_addr
//   st                ADB state: 00 cmd, 01 even byte, 10 odd byte, 11 idle
//   adb_din/_strobe   byte to device, with a one-tick strobe
//   dev_dout/_strobe  byte from device, with its strobe
//   dev_int_n         device service request, active low
//
// State table
//   state    | meaning
//   S_IDLE   | st=11, accept CPU request or launch autopoll
//   S_CMD    | command byte on adb_din (strobe asserted on entry)
//   S_GAP    | st held at 00 for one tick after the command strobe
//   S_BYTE0  | st=01, first data byte (sent for Listen, received otherwise)
//   S_BYTE1  | st=10, second data byte
//   S_FINISH | st=11, done/poll_valid visible, choose next poll target

module adb_poller #(
    parameter logic [16:0] POLL_INTERVAL = 17'd88000,
    parameter logic [11:0] TIMEOUT       = 12'd2000,
    parameter logic [3:0]  KBD_ADDR      = 4'd2,
    parameter logic [3:0]  MOUSE_ADDR    = 4'd3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        req,
    output logic        req_ready,
    input  logic [7:0]  req_cmd,
    input  logic [15:0] req_data,
    output logic        done,
    output logic [15:0] rsp_data,
    output logic [1:0]  rsp_cnt,
    output logic        timeout,
    input  logic        autopoll_en,
    output logic        poll_valid,
    output logic [3:0]  poll_addr,
    output logic [1:0]  st,
    output logic [7:0]  adb_din,
    output logic        adb_din_strobe,
    input  logic [7:0]  dev_dout,
    input  logic        dev_dout_strobe,
    input  logic        dev_int_n
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_GAP,
        S_BYTE0,
        S_BYTE1,
        S_FINISH
    } state_t;

    state_t      r_state;
    logic [7:0]  r_cmd;
    logic [15:0] r_data;
    logic        r_is_poll;
    logic [3:0]  r_poll_tgt;
    logic [3:0]  r_poll_addr;
    logic [16:0] r_pcnt;
    logic [11:0] r_tcnt;
    logic        r_sent;
    logic        r_req_ready;
    logic        r_done;
    logic        r_timeout;
    logic        r_poll_valid;
    logic [15:0] r_rsp_data;
    logic [1:0]  r_rsp_cnt;
    logic [1:0]  r_st;
    logic [7:0]  r_adb_din;
    logic        r_adb_din_strobe;

    logic        w_is_talk;
    logic        w_is_listen;
    logic        w_in_byte;
    logic        w_poll_due;
    logic        w_tmo;
    logic        w_cap;
    logic [1:0]  w_cnt_next;
    logic [3:0]  w_other;
    logic [3:0]  w_alt;

    assign w_is_talk   = (r_cmd[3:2] == 2'b11);
    assign w_is_listen = (r_cmd[3:2] == 2'b10);
    assign w_in_byte   = (r_state == S_BYTE0) || (r_state == S_BYTE1);
    // >= rather than == so an expiry lost to a CPU request stays pending
    // until the bus is idle again.
    assign w_poll_due  = autopoll_en && (r_pcnt >= POLL_INTERVAL - 17'd1);
    assign w_tmo       = (r_tcnt == TIMEOUT - 12'd1);
    // A device byte is only taken while receiving; an SRQ byte sent while
    // the bus is idle must not reach rsp_data.
    assign w_cap       = w_in_byte && !w_is_listen && dev_dout_strobe;
    assign w_cnt_next  = r_rsp_cnt + {1'b0, w_cap};
    // Serviced device asks again: poll the other one. Otherwise just
    // alternate the rotating target.
    assign w_other     = (r_poll_addr == KBD_ADDR) ? MOUSE_ADDR : KBD_ADDR;
    assign w_alt       = (r_poll_tgt == KBD_ADDR) ? MOUSE_ADDR : KBD_ADDR;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_cmd            <= 8'h00;
            r_data           <= 16'h0000;
            r_is_poll        <= 1'b0;
            r_poll_tgt       <= KBD_ADDR;
            r_poll_addr      <= KBD_ADDR;
            r_pcnt           <= 17'd0;
            r_tcnt           <= 12'd0;
            r_sent           <= 1'b0;
            r_req_ready      <= 1'b1;
            r_done           <= 1'b0;
            r_timeout        <= 1'b0;
            r_poll_valid     <= 1'b0;
            r_rsp_data       <= 16'h0000;
            r_rsp_cnt        <= 2'd0;
            r_st             <= 2'b11;
            r_adb_din        <= 8'h00;
            r_adb_din_strobe <= 1'b0;
        end else begin
            // Pulses last one clk, even when clk_en is sparse.
            r_done           <= 1'b0;
            r_poll_valid     <= 1'b0;
            r_adb_din_strobe <= 1'b0;

            if (clk_en) begin
                if (!autopoll_en) begin
                    r_pcnt <= 17'd0;
                end

                case (r_state)
                    S_IDLE: begin
                        if (autopoll_en && !w_poll_due) begin
                            r_pcnt <= r_pcnt + 17'd1;
                        end
                        if (req) begin
                            r_cmd            <= req_cmd;
                            r_data           <= req_data;
                            r_is_poll        <= 1'b0;
                            r_adb_din        <= req_cmd;
                            r_adb_din_strobe <= 1'b1;
                            r_st             <= 2'b00;
                            r_req_ready      <= 1'b0;
                            r_state          <= S_CMD;
                        end else if (w_poll_due) begin
                            r_cmd            <= {r_poll_tgt, 4'hC};
                            r_data           <= 16'h0000;
                            r_is_poll        <= 1'b1;
                            r_poll_addr      <= r_poll_tgt;
                            r_pcnt           <= 17'd0;
                            r_adb_din        <= {r_poll_tgt, 4'hC};
                            r_adb_din_strobe <= 1'b1;
                            r_st             <= 2'b00;
                            r_req_ready      <= 1'b0;
                            r_state          <= S_CMD;
                        end
                    end

                    S_CMD: begin
                        r_rsp_cnt  <= 2'd0;
                        r_rsp_data <= 16'h0000;
                        r_state    <= S_GAP;
                    end

                    S_GAP: begin
                        r_st    <= 2'b01;
                        r_tcnt  <= 12'd0;
                        r_sent  <= 1'b0;
                        r_state <= S_BYTE0;
                    end

                    S_BYTE0, S_BYTE1: begin
                        if (w_is_listen && !r_sent) begin
                            r_adb_din        <= (r_state == S_BYTE0) ? r_data[15:8] : r_data[7:0];
                            r_adb_din_strobe <= 1'b1;
                            r_sent           <= 1'b1;
                        end else if (w_is_listen || w_cap || w_tmo) begin
                            if (w_cap) begin
                                if (r_state == S_BYTE0) begin
                                    r_rsp_data[15:8] <= dev_dout;
                                end else begin
                                    r_rsp_data[7:0] <= dev_dout;
                                end
                                r_rsp_cnt <= w_cnt_next;
                            end
                            // A timeout with no byte ends the transaction
                            // from either byte state.
                            if (r_state == S_BYTE0 && (w_is_listen || w_cap)) begin
                                r_st    <= 2'b10;
                                r_tcnt  <= 12'd0;
                                r_sent  <= 1'b0;
                                r_state <= S_BYTE1;
                            end else begin
                                r_st    <= 2'b11;
                                r_state <= S_FINISH;
                                if (r_is_poll) begin
                                    r_poll_valid <= (w_cnt_next == 2'd2);
                                end else begin
                                    r_done    <= 1'b1;
                                    r_timeout <= w_is_talk && (w_cnt_next != 2'd2);
                                end
                            end
                        end else begin
                            r_tcnt <= r_tcnt + 12'd1;
                        end
                    end

                    S_FINISH: begin
                        if (r_is_poll) begin
                            r_poll_tgt <= (!dev_int_n) ? w_other : w_alt;
                        end
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end

                    default: begin
                        r_st        <= 2'b11;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign req_ready      = r_req_ready;
    assign done           = r_done;
    assign timeout        = r_timeout;
    assign rsp_data       = r_rsp_data;
    assign rsp_cnt        = r_rsp_cnt;
    assign poll_valid     = r_poll_valid;
    assign poll_addr      = r_poll_addr;
    assign st             = r_st;
    assign adb_din        = r_adb_din;
    assign adb_din_strobe = r_adb_din_strobe;

endmodule

// File: tb/tb_adb_poller.sv
// tb_adb_poller -- directed self-checking bench for adb_poller.
// Short poll interval and timeout keep the run small. The bench drives inputs
// and samples outputs 1 ns after each rising edge.

module tb_adb_poller;

    localparam logic [16:0] PI = 17'd40;
    localparam logic [11:0] TO = 12'd10;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en;
    logic        req;
    logic        req_ready;
    logic [7:0]  req_cmd;
    logic [15:0] req_data;
    logic        done;
    logic [15:0] rsp_data;
    logic [1:0]  rsp_cnt;
    logic        timeout;
    logic        autopoll_en;
    logic        poll_valid;
    logic [3:0]  poll_addr;
    logic [1:0]  st;
    logic [7:0]  adb_din;
    logic        adb_din_strobe;
    logic [7:0]  dev_dout;
    logic        dev_dout_strobe;
    logic        dev_int_n;

    int checks   = 0;
    int failures = 0;

    logic [7:0] slog [0:255];
    int n_strb = 0;
    int n_done = 0;
    int n_pv   = 0;

    always #5 clk = ~clk;

    adb_poller #(
        .POLL_INTERVAL(PI),
        .TIMEOUT(TO),
        .KBD_ADDR(4'd2),
        .MOUSE_ADDR(4'd3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .clk_en(clk_en),
        .req(req),
        .req_ready(req_ready),
        .req_cmd(req_cmd),
        .req_data(req_data),
        .done(done),
        .rsp_data(rsp_data),
        .rsp_cnt(rsp_cnt),
        .timeout(timeout),
        .autopoll_en(autopoll_en),
        .poll_valid(poll_valid),
        .poll_addr(poll_addr),
        .st(st),
        .adb_din(adb_din),
        .adb_din_strobe(adb_din_strobe),
        .dev_dout(dev_dout),
        .dev_dout_strobe(dev_dout_strobe),
        .dev_int_n(dev_int_n)
    );

    // Byte strobes to the device, done pulses and poll_valid pulses.
    always @(posedge clk) begin
        if (adb_din_strobe) begin
            if (n_strb < 256) slog[n_strb[7:0]] <= adb_din;
            n_strb <= n_strb + 1;
        end
        if (done) n_done <= n_done + 1;
        if (poll_valid) n_pv <= n_pv + 1;
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; req = 1'b0; dev_dout_strobe = 1'b0;
        step();
        reset = 1'b0;
    endtask

    // Accepts a request on the next tick, then drops req.
    task automatic issue(input logic [7:0] cmd, input logic [15:0] data);
        req = 1'b1; req_cmd = cmd; req_data = data;
        step();
        req = 1'b0;
    endtask

    task automatic dev_byte(input logic [7:0] b);
        dev_dout = b; dev_dout_strobe = 1'b1;
        step();
        dev_dout_strobe = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(3);
        checks++; if (st !== 2'b11) begin failures++; $display("FAIL rst_st got=%b exp=11", st); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
        checks++; if ({done, poll_valid, adb_din_strobe, timeout} !== 4'b0000) begin failures++; $display("FAIL rst_pulses got=%b exp=0000", {done, poll_valid, adb_din_strobe, timeout}); end
        checks++; if ({adb_din, rsp_data, rsp_cnt} !== 26'd0) begin failures++; $display("FAIL rst_data got=%h/%h/%0d exp=0", adb_din, rsp_data, rsp_cnt); end
        reset = 1'b0;
    endtask

    task automatic test_cpu_talk();
        int base;
        base = n_strb;
        issue(8'h3C, 16'h0000);
        checks++; if ({adb_din_strobe, adb_din, st} !== {1'b1, 8'h3C, 2'b00}) begin failures++; $display("FAIL talk_cmd got=%b/%h/%b exp=1/3c/00", adb_din_strobe, adb_din, st); end
        step();
        checks++; if ({adb_din_strobe, st} !== 3'b000) begin failures++; $display("FAIL talk_gap got=%b/%b exp=0/00", adb_din_strobe, st); end
        step();
        checks++; if (st !== 2'b01) begin failures++; $display("FAIL talk_st_byte0 got=%b exp=01", st); end
        dev_byte(8'h7F);
        checks++; if ({st, rsp_cnt, rsp_data[15:8]} !== {2'b10, 2'd1, 8'h7F}) begin failures++; $display("FAIL talk_byte0 got=%b/%0d/%h exp=10/1/7f", st, rsp_cnt, rsp_data[15:8]); end
        clk_en = 1'b0;
        step(3);
        checks++; if ({st, done} !== 3'b100) begin failures++; $display("FAIL talk_clk_en_hold got=%b/%b exp=10/0", st, done); end
        clk_en = 1'b1;
        step(2);
        dev_byte(8'hAA);
        checks++; if ({done, timeout, st} !== 4'b1011) begin failures++; $display("FAIL talk_done got=%b/%b/%b exp=1/0/11", done, timeout, st); end
        checks++; if ({rsp_data, rsp_cnt} !== {16'h7FAA, 2'd2}) begin failures++; $display("FAIL talk_rsp got=%h/%0d exp=7faa/2", rsp_data, rsp_cnt); end
        step();
        checks++; if ({done, req_ready} !== 2'b01) begin failures++; $display("FAIL talk_after got=%b/%b exp=0/1", done, req_ready); end
        checks++; if (n_strb - base !== 1) begin failures++; $display("FAIL talk_strobes got=%0d exp=1", n_strb - base); end
    endtask

    task automatic test_listen();
        int base;
        int d0;
        base = n_strb;
        d0 = n_done;
        issue(8'h2A, 16'h1234);
        step(5);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL listen_early_done got=%b exp=0", done); end
        step();
        checks++; if ({done, timeout, rsp_cnt} !== {1'b1, 1'b0, 2'd0}) begin failures++; $display("FAIL listen_done got=%b/%b/%0d exp=1/0/0", done, timeout, rsp_cnt); end
        step(2);
        checks++; if (n_strb - base !== 3) begin failures++; $display("FAIL listen_nstrb got=%0d exp=3", n_strb - base); end
        checks++; if ({slog[base[7:0]], slog[base[7:0]+8'd1], slog[base[7:0]+8'd2]} !== 24'h2A1234) begin failures++; $display("FAIL listen_bytes got=%h%h%h exp=2a1234", slog[base[7:0]], slog[base[7:0]+8'd1], slog[base[7:0]+8'd2]); end
        checks++; if (n_done - d0 !== 1) begin failures++; $display("FAIL listen_ndone got=%0d exp=1", n_done - d0); end
    endtask

    task automatic test_timeout();
        issue(8'h3C, 16'h0000);
        step();
        checks++; if ({rsp_data, rsp_cnt} !== 18'd0) begin failures++; $display("FAIL tmo_clear got=%h/%0d exp=0/0", rsp_data, rsp_cnt); end
        step();
        dev_byte(8'h55);
        step(int'(TO) - 1);
        checks++; if ({done, st} !== 3'b010) begin failures++; $display("FAIL tmo_early got=%b/%b exp=0/10", done, st); end
        step();
        checks++; if ({done, timeout, rsp_cnt, rsp_data} !== {1'b1, 1'b1, 2'd1, 16'h5500}) begin failures++; $display("FAIL tmo_done got=%b/%b/%0d/%h exp=1/1/1/5500", done, timeout, rsp_cnt, rsp_data); end
        step(2);
        // Idle-state SRQ byte from the device.
        dev_byte(8'hFF);
        step();
        checks++; if ({rsp_data, rsp_cnt, st} !== {16'h5500, 2'd1, 2'b11}) begin failures++; $display("FAIL srq_ignored got=%h/%0d/%b exp=5500/1/11", rsp_data, rsp_cnt, st); end
    endtask

    task automatic test_timeout_edge();
        issue(8'h3C, 16'h0000);
        step(2);
        dev_byte(8'h55);
        step(int'(TO) - 1);
        dev_byte(8'h66);
        checks++; if ({done, timeout, rsp_cnt, rsp_data} !== {1'b1, 1'b0, 2'd2, 16'h5566}) begin failures++; $display("FAIL tmo_edge got=%b/%b/%0d/%h exp=1/0/2/5566", done, timeout, rsp_cnt, rsp_data); end
        step(2);
    endtask

    task automatic test_autopoll();
        int d0;
        do_reset();
        d0 = n_done;
        autopoll_en = 1'b1;
        step(int'(PI) - 1);
        checks++; if (adb_din_strobe !== 1'b0) begin failures++; $display("FAIL poll1_early got=%b exp=0", adb_din_strobe); end
        step();
        checks++; if ({adb_din_strobe, adb_din} !== {1'b1, 8'h2C}) begin failures++; $display("FAIL poll1_cmd got=%b/%h exp=1/2c", adb_din_strobe, adb_din); end
        step(2);
        dev_byte(8'h11);
        dev_byte(8'h22);
        checks++; if ({poll_valid, poll_addr, done} !== {1'b1, 4'd2, 1'b0}) begin failures++; $display("FAIL poll1_valid got=%b/%h/%b exp=1/2/0", poll_valid, poll_addr, done); end
        dev_int_n = 1'b1;
        step();
        step(int'(PI) - 1);
        checks++; if (adb_din_strobe !== 1'b0) begin failures++; $display("FAIL poll2_early got=%b exp=0", adb_din_strobe); end
        step();
        checks++; if ({adb_din_strobe, adb_din} !== {1'b1, 8'h3C}) begin failures++; $display("FAIL poll2_cmd got=%b/%h exp=1/3c", adb_din_strobe, adb_din); end
        step(2);
        dev_byte(8'h33);
        dev_byte(8'h44);
        checks++; if ({poll_valid, poll_addr, rsp_data} !== {1'b1, 4'd3, 16'h3344}) begin failures++; $display("FAIL poll2_valid got=%b/%h/%h exp=1/3/3344", poll_valid, poll_addr, rsp_data); end
        dev_int_n = 1'b0;
        step();
        dev_int_n = 1'b1;
        step(int'(PI));
        checks++; if ({adb_din_strobe, adb_din} !== {1'b1, 8'h2C}) begin failures++; $display("FAIL poll3_srq_target got=%b/%h exp=1/2c", adb_din_strobe, adb_din); end
        checks++; if (n_done - d0 !== 0) begin failures++; $display("FAIL poll_no_done got=%0d exp=0", n_done - d0); end
        autopoll_en = 1'b0;
        do_reset();
    endtask

    task automatic test_arbitration();
        int p0;
        do_reset();
        autopoll_en = 1'b1;
        step(int'(PI) - 1);
        issue(8'h2A, 16'hABCD);
        checks++; if ({adb_din_strobe, adb_din} !== {1'b1, 8'h2A}) begin failures++; $display("FAIL arb_cpu_wins got=%b/%h exp=1/2a", adb_din_strobe, adb_din); end
        step(6);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL arb_done got=%b exp=1", done); end
        step();
        checks++; if (adb_din_strobe !== 1'b0) begin failures++; $display("FAIL arb_finish got=%b exp=0", adb_din_strobe); end
        step();
        checks++; if ({adb_din_strobe, adb_din} !== {1'b1, 8'h2C}) begin failures++; $display("FAIL arb_poll_after got=%b/%h exp=1/2c", adb_din_strobe, adb_din); end
        // Silent device: the poll times out in BYTE0 without poll_valid.
        p0 = n_pv;
        step(2 + int'(TO) + 2);
        checks++; if ({n_pv - p0, st} !== {32'd0, 2'b11}) begin failures++; $display("FAIL arb_poll_silent got=%0d/%b exp=0/11", n_pv - p0, st); end
        autopoll_en = 1'b0;
        do_reset();
    endtask

    task automatic test_reset_mid();
        int d0;
        d0 = n_done;
        issue(8'h3C, 16'h0000);
        step(3);
        checks++; if (st !== 2'b01) begin failures++; $display("FAIL rmid_in_byte0 got=%b exp=01", st); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if ({st, done, req_ready} !== 4'b1101) begin failures++; $display("FAIL rmid_idle got=%b/%b/%b exp=11/0/1", st, done, req_ready); end
        issue(8'h3C, 16'h0000);
        checks++; if ({adb_din_strobe, adb_din} !== {1'b1, 8'h3C}) begin failures++; $display("FAIL rmid_accept got=%b/%h exp=1/3c", adb_din_strobe, adb_din); end
        do_reset();
        step(2);
        checks++; if (n_done - d0 !== 0) begin failures++; $display("FAIL rmid_no_done got=%0d exp=0", n_done - d0); end
    endtask

    initial begin
        reset = 1'b1; clk_en = 1'b1; req = 1'b0; req_cmd = 8'h00; req_data = 16'h0000;
        autopoll_en = 1'b0; dev_dout = 8'h00; dev_dout_strobe = 1'b0; dev_int_n = 1'b1;
        test_reset();
        test_cpu_talk();
        test_listen();
        test_timeout();
        test_timeout_edge();
        test_autopoll();
        test_arbitration();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
